// File: rtl/led_mode_ctrl_pkg.sv
// Shared definitions for the LED mode controller and the LED shifter it drives.
//   - OP_* : shifter operation codes; the mode register uses the same encoding.
//   - mode_e : FSM state type, numerically identical to the op codes.
//   - CNT_W_DEF / DB_W_DEF : default step-tick and debounce counter widths.
package led_mode_ctrl_pkg;

    localparam int unsigned CNT_W_DEF = 23;
    localparam int unsigned DB_W_DEF  = 20;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_ROTL = 2'b01;
    localparam logic [1:0] OP_ROTR = 2'b10;
    localparam logic [1:0] OP_INV  = 2'b11;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRotl  = 2'b01,
        StRotr  = 2'b10,
        StBlink = 2'b11
    } mode_e;

endpackage

// File: rtl/sw_debounce.sv
// One push switch: 2-flop synchronizer, debounce filter and press detector.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous reset, active-high despite the name
//   sw_raw : raw asynchronous switch level, active-low
//   press  : one-cycle pulse in the cycle the debounced level falls 1 -> 0
module sw_debounce
    import led_mode_ctrl_pkg::*;
#(
    parameter int unsigned DB_W = DB_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_raw,
    output logic press
);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            db_q, db_d;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            press_q, press_d;

    always_comb begin
        sync1_d = sw_raw;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = '0;
        // Count consecutive cycles of disagreement; any agreement clears the count.
        if (sync2_q != db_q) begin
            if (cnt_q == {DB_W{1'b1}}) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = db_q & ~db_d;
    end

    // Idle level is "released" (1), so reset never manufactures a press.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            db_q    <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// LED mode controller: three debounced push switches select a shifter mode,
// and a free-running tick counter issues periodic step strobes in that mode.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous reset, active-high despite the name
//   sw    : raw active-low switches sw[3:1]
//   step  : one-cycle strobe telling the LED shifter to advance
//   op    : shifter operation while step=1, OP_HOLD otherwise
//   mode  : current FSM state (same encoding as op)
module led_mode_ctrl
    import led_mode_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned DB_W  = DB_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:1] sw,
    output logic       step,
    output logic [1:0] op,
    output logic [1:0] mode
);

    logic [3:1] press;

    for (genvar k = 1; k <= 3; k++) begin : g_sw
        sw_debounce #(
            .DB_W(DB_W)
        ) u_sw_debounce (
            .clk   (clk),
            .rst_n (rst_n),
            .sw_raw(sw[k]),
            .press (press[k])
        );
    end

    mode_e            mode_q, mode_d;
    mode_e            target;
    logic             hit;
    logic             change;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_q, step_d;
    logic [1:0]       op_q, op_d;

    always_comb begin
        mode_d = mode_q;
        target = StIdle;
        hit    = 1'b0;
        // Fixed priority sw1 > sw2 > sw3; losing presses are dropped.
        if (press[1]) begin
            target = StRotl;
            hit    = 1'b1;
        end else if (press[2]) begin
            target = StRotr;
            hit    = 1'b1;
        end else if (press[3]) begin
            target = StBlink;
            hit    = 1'b1;
        end
        if (hit) begin
            mode_d = (mode_q == target) ? StIdle : target;
        end
        change = (mode_d != mode_q);

        if ((mode_q == StIdle) || change) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // A mode change in the terminal-count cycle suppresses the old mode's step.
        step_d = (mode_q != StIdle) && !change && (cnt_q == {CNT_W{1'b1}});
        op_d   = OP_HOLD;
        if (step_d) begin
            op_d = mode_q;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            mode_q <= StIdle;
            cnt_q  <= '0;
            step_q <= 1'b0;
            op_q   <= OP_HOLD;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            step_q <= step_d;
            op_q   <= op_d;
        end
    end

    assign step = step_q;
    assign op   = op_q;
    assign mode = mode_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
module tb_led_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:1] sw;
    logic       step;
    logic [1:0] op;
    logic [1:0] mode;

    int n_vec    = 0;
    int n_bad    = 0;
    int step_cnt = 0;
    int snap;

    led_mode_ctrl #(
        .CNT_W(4),
        .DB_W (3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sw   (sw),
        .step (step),
        .op   (op),
        .mode (mode)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (step === 1'b1) step_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input logic [1:0] m, input logic s, input logic [1:0] o);
        chk({tag, "_mode"}, {30'd0, mode}, {30'd0, m});
        chk({tag, "_step"}, {31'd0, step}, {31'd0, s});
        chk({tag, "_op"}, {30'd0, op}, {30'd0, o});
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with switches toggling.
        rst_n = 1'b1;
        sw    = 3'b111;
        #1;
        outs("rst_async", 2'b00, 1'b0, 2'b00);
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            sw = 3'($urandom_range(0, 7));
            outs("rst_hold", 2'b00, 1'b0, 2'b00);
        end
        sw = 3'b111;
        cyc(2);
        rst_n = 1'b0;
        snap  = step_cnt;
        cyc(40);
        outs("rst_after", 2'b00, 1'b0, 2'b00);
        chk("rst_no_step", step_cnt, snap);

        // Bounce on sw1, then steady low; mode change edge M is 11 edges later.
        sw[1] = 1'b0;
        cyc(5);
        sw[1] = 1'b1;
        cyc(2);
        sw[1] = 1'b0;
        chk("bounce_start", {30'd0, mode}, 32'd0);
        cyc(10);
        chk("bounce_early", {30'd0, mode}, 32'd0);
        cyc(1);
        chk("bounce_mode", {30'd0, mode}, 32'd1);
        snap = step_cnt;
        cyc(15);
        outs("rotl_m15", 2'b01, 1'b0, 2'b00);
        cyc(1);
        outs("rotl_m16", 2'b01, 1'b1, 2'b01);
        cyc(1);
        outs("rotl_m17", 2'b01, 1'b0, 2'b00);
        cyc(15);
        outs("rotl_m32", 2'b01, 1'b1, 2'b01);
        sw[1] = 1'b1;
        cyc(15);
        chk("release_no_event", {30'd0, mode}, 32'd1);
        chk("rotl_step_count", step_cnt, snap + 2);

        // Toggle: pressing sw1 in ROTL returns to IDLE.
        sw[1] = 1'b0;
        cyc(10);
        chk("toggle_early", {30'd0, mode}, 32'd1);
        cyc(1);
        outs("toggle", 2'b00, 1'b0, 2'b00);
        chk("toggle_cnt", {28'd0, dut.cnt_q}, 32'd0);
        chk("toggle_steps", step_cnt, snap + 3);
        snap = step_cnt;
        cyc(40);
        chk("idle_no_step", step_cnt, snap);
        chk("idle_cnt", {28'd0, dut.cnt_q}, 32'd0);
        sw[1] = 1'b1;
        cyc(12);
        chk("idle_release", {30'd0, mode}, 32'd0);

        // Priority: sw1 and sw3 together.
        sw = 3'b010;
        cyc(11);
        chk("prio_mode", {30'd0, mode}, 32'd1);
        cyc(20);
        chk("prio_sw3_held", {30'd0, mode}, 32'd1);
        sw = 3'b111;
        cyc(12);
        chk("prio_release", {30'd0, mode}, 32'd1);
        sw[3] = 1'b0;
        cyc(11);
        chk("prio_sw3_again", {30'd0, mode}, 32'd3);
        sw[3] = 1'b1;
        cyc(12);
        chk("blink_hold", {30'd0, mode}, 32'd3);

        // Collision: sw2 change lands on counter=15 in ROTL.
        sw[1] = 1'b0;
        cyc(11);
        chk("coll_rotl", {30'd0, mode}, 32'd1);
        sw[1] = 1'b1;
        cyc(5);
        sw[2] = 1'b0;
        cyc(10);
        outs("coll_m15", 2'b01, 1'b0, 2'b00);
        chk("coll_cnt15", {28'd0, dut.cnt_q}, 32'd15);
        snap = step_cnt;
        cyc(1);
        outs("coll_m16", 2'b10, 1'b0, 2'b00);
        chk("coll_cnt0", {28'd0, dut.cnt_q}, 32'd0);
        cyc(15);
        outs("coll_m31", 2'b10, 1'b0, 2'b00);
        chk("coll_no_step", step_cnt, snap);
        cyc(1);
        outs("coll_m32", 2'b10, 1'b1, 2'b10);
        sw[2] = 1'b1;
        cyc(12);

        // Mid-period reset in BLINK at counter=10.
        sw[3] = 1'b0;
        cyc(11);
        chk("mid_blink", {30'd0, mode}, 32'd3);
        cyc(10);
        chk("mid_cnt10", {28'd0, dut.cnt_q}, 32'd10);
        snap  = step_cnt;
        rst_n = 1'b1;
        #1;
        outs("mid_rst", 2'b00, 1'b0, 2'b00);
        chk("mid_rst_cnt", {28'd0, dut.cnt_q}, 32'd0);
        sw[3] = 1'b1;
        cyc(3);
        rst_n = 1'b0;
        cyc(40);
        outs("mid_after", 2'b00, 1'b0, 2'b00);
        chk("mid_no_step", step_cnt, snap);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/led_mode_ctrl.md
LED_MODE_CTRL -- requirements
Module: led_mode_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 23, giving the step-tick counter width; the step period is 2^CNT_W clk cycles.
REQ-002 The block SHALL have parameter DB_W, default 20, giving the debounce counter width; the stable time is 2^DB_W clk cycles.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous reset, active-high (1 = reset asserted).
REQ-005 The block SHALL have port sw[3:1], input, 3 bits: raw, asynchronous, active-low push switches.
REQ-006 The block SHALL have port step, output, 1 bit: a one-cycle strobe that commands the LED shifter to advance.
REQ-007 The block SHALL have port op[1:0], output, 2 bits: the shifter operation, 00 hold, 01 rotate-left, 10 rotate-right, 11 invert.
REQ-008 The block SHALL have port mode[1:0], output, 2 bits: the current FSM state, encoded the same as op.

Function
REQ-009 Each sw[k] SHALL pass through a 2-flop synchronizer before any other use.
REQ-010 A debounced level db[k] SHALL take the synchronized value only after that value has differed from db[k] for 2^DB_W consecutive cycles; any bounce back to db[k] SHALL restart the count.
REQ-011 press[k] SHALL pulse for one cycle on the cycle db[k] goes from 1 to 0; release SHALL generate no event.
REQ-012 The FSM SHALL have four states: IDLE=00, ROTL=01, ROTR=10, BLINK=11.
REQ-013 press[1] SHALL move the FSM to ROTL, press[2] to ROTR and press[3] to BLINK, from any state.
REQ-014 A press of the switch that owns the current state (e.g. press[1] while in ROTL) SHALL return the FSM to IDLE.
REQ-015 Simultaneous presses SHALL be resolved with priority sw1 > sw2 > sw3, and only the winning press SHALL be acted on.
REQ-016 The mode register SHALL update on the clock edge following the press[k] pulse, i.e. 1 cycle after the debounced edge.
REQ-017 The tick counter SHALL be held at 0 in IDLE and SHALL be cleared on every state change.
REQ-018 Outside IDLE the tick counter SHALL increment by 1 each cycle, modulo 2^CNT_W.
REQ-019 step SHALL be 1 exactly in the cycle the counter equals 2^CNT_W-1 while not in IDLE.
  - The first step after entering a mode therefore comes 2^CNT_W cycles after the mode change.
  - Steps then repeat every 2^CNT_W cycles.
REQ-020 If a state change coincides with a counter value of 2^CNT_W-1, the change SHALL win: no step for the old mode and the counter restarts from 0.
REQ-021 op SHALL equal mode whenever step=1 and SHALL be 00 otherwise.
REQ-022 step, op and mode SHALL be registered outputs.

Reset
REQ-023 While rst_n=1 the block SHALL force mode=IDLE, step=0, op=00, tick counter=0, debounce counters=0, synchronizer flops=1 and db=3'b111.
REQ-024 A reset asserted mid-period or mid-debounce SHALL discard the pending step or press; no event SHALL be produced on reset release.

Structure
REQ-025 A shared package SHALL hold the op/mode encodings (OP_HOLD, OP_ROTL, OP_ROTR, OP_INV) and the default CNT_W and DB_W values, for reuse by the LED shifter.
REQ-026 Synchronizer, debounce and edge detect for one switch SHALL be a sub-module sw_debounce, instantiated three times.
REQ-027 The FSM and the tick counter SHALL reside in led_mode_ctrl itself.

Verification (benches run with CNT_W=4, DB_W=3)
REQ-028 Reset scenario: hold rst_n=1 with sw toggling, then release -> mode=00, step=0, op=00 throughout, and no press event afterwards.
REQ-029 Bounce scenario: sw[1] low for 5 cycles, high for 2, then low steady -> exactly one press, mode=01 no earlier than 8 stable cycles after the last bounce; step first at 16 cycles after the mode change, then every 16 cycles with op=01.
REQ-030 Toggle scenario: in ROTL press sw1 again -> mode=00, counter 0, no further step.
REQ-031 Priority scenario: sw1 and sw3 pressed on the same cycle from IDLE -> mode=01; sw3 is ignored until it is released and pressed again.
REQ-032 Collision scenario: press sw2 timed so the mode change lands on counter=15 in ROTL -> no step on that cycle, mode=10, next step 16 cycles later with op=10.
REQ-033 Mid-period reset scenario: assert rst_n at counter=10 in BLINK -> outputs are at reset values immediately (asynchronous) and no step occurs after release.
